// File: rtl/tb_uart_pkg.sv
// tb_uart_pkg: shared state encoding and default constants for the 8N1 board-side UART receiver.
`default_nettype none

package tb_uart_pkg;

   localparam int         DEFAULT_CLKS_PER_BIT = 4167;   // 40 MHz / 9600 baud
   localparam logic [7:0] DEFAULT_EOL_CHAR     = 8'h0A;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } uart_rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous bit, with selectable reset value.
`default_nettype none

module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ff_q <= {2{RESET_VAL}};
      end else begin
         ff_q <= {ff_q[0], d_i};
      end
   end

   assign q_o = ff_q[1];

endmodule

`default_nettype wire

// File: rtl/tb_uart.sv
// tb_uart: 8N1 UART receiver watching the Caravel UART TX pad; emits each byte with
// line-end and framing-error pulses.
`default_nettype none

module tb_uart
   import tb_uart_pkg::*;
#(
   parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter logic [7:0] EOL_CHAR     = DEFAULT_EOL_CHAR
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic       ser_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_eol,
   output logic       frame_err,
   output logic       busy
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_TERM = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_TERM = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic rx_s;

   uart_rx_state_t state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     rx_data_q, rx_data_d;
   logic           rx_valid_q, rx_valid_d;
   logic           rx_eol_q, rx_eol_d;
   logic           frame_err_q, frame_err_d;
   logic           tick;

   sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync_rx (
      .clk_i  (clock),
      .rst_ni (resetb),
      .d_i    (ser_rx),
      .q_o    (rx_s)
   );

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         rx_eol_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_eol_q    <= rx_eol_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      rx_eol_d    = 1'b0;
      frame_err_d = 1'b0;

      // The start-bit wait is half a bit so later samples land mid-bit.
      tick  = (state_q == ST_START) ? (cnt_q == HALF_TERM) : (cnt_q == FULL_TERM);
      cnt_d = tick ? cnt_q : (cnt_q + CNT_ONE);

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = ST_START;
               bit_d   = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = '0;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (rx_s) begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
                  rx_eol_d   = (shift_q == EOL_CHAR);
                  state_d    = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_WAIT_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

   always_comb begin
      busy      = (state_q != ST_IDLE);
      rx_data   = rx_data_q;
      rx_valid  = rx_valid_q;
      rx_eol    = rx_eol_q;
      frame_err = frame_err_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_tb_uart.sv
// tb_tb_uart: directed stimulus for tb_uart with a queue-based scoreboard and pulse monitor.
`timescale 1ns/1ps
`default_nettype none

module tb_tb_uart;

   localparam int CPB = 16;

   logic       clock  = 1'b0;
   logic       resetb = 1'b0;
   logic       ser_rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_eol;
   logic       frame_err;
   logic       busy;

   tb_uart #(
      .CLKS_PER_BIT (CPB),
      .EOL_CHAR     (8'h0A)
   ) dut (
      .clock     (clock),
      .resetb    (resetb),
      .ser_rx    (ser_rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_eol    (rx_eol),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #12.5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      bit         eol;
      int         exp_cyc;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_good = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_good(input logic [7:0] b, input int c);
      exp_t e;
      e.is_err  = 1'b0;
      e.data    = b;
      e.eol     = (b == 8'h0A);
      e.exp_cyc = c;
      sb.push_back(e);
      last_good = b;
   endtask

   task automatic push_err(input int c);
      exp_t e;
      e.is_err  = 1'b1;
      e.data    = last_good;
      e.eol     = 1'b0;
      e.exp_cyc = c;
      sb.push_back(e);
   endtask

   // Clock-aligned frame; call at a falling edge. Leaves the line at the stop level.
   task automatic send(input logic [7:0] b, input bit stop_ok);
      ser_rx = 1'b0;
      if (stop_ok) push_good(b, cyc + 155);
      else         push_err(cyc + 155);
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         ser_rx = b[i];
         repeat (CPB) @(negedge clock);
      end
      ser_rx = stop_ok;
      repeat (CPB) @(negedge clock);
   endtask

   // Free-running frame at an arbitrary bit period, asynchronous to the clock.
   task automatic send_rate(input logic [7:0] b, input realtime bit_ns);
      push_good(b, -1);
      ser_rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         ser_rx = b[i];
         #(bit_ns);
      end
      ser_rx = 1'b1;
      #(bit_ns);
   endtask

   always @(negedge clock) begin
      if (resetb) begin
         if (rx_eol) chk("eol_needs_valid", rx_valid, 1);
         if (rx_valid || frame_err) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: valid=%b ferr=%b data=%h, expected no pulse (t=%0t)",
                        rx_valid, frame_err, rx_data, $time);
            end else begin
               mon_e = sb.pop_front();
               if (mon_e.is_err) begin
                  chk("ferr_flag", frame_err, 1);
                  chk("ferr_no_valid", rx_valid, 0);
                  chk("ferr_held_data", rx_data, mon_e.data);
               end else begin
                  chk("valid_flag", rx_valid, 1);
                  chk("valid_no_ferr", frame_err, 0);
                  chk("rx_data", rx_data, mon_e.data);
                  chk("rx_eol", rx_eol, mon_e.eol);
               end
               if (mon_e.exp_cyc >= 0) chk("pulse_latency", cyc, mon_e.exp_cyc);
            end
         end
      end
   end

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_rx_data"}, rx_data, 0);
      chk({tag, "_rx_valid"}, rx_valid, 0);
      chk({tag, "_rx_eol"}, rx_eol, 0);
      chk({tag, "_frame_err"}, frame_err, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      chk_outputs_zero("por");
      resetb = 1'b1;
      repeat (5) @(negedge clock);

      send(8'h55, 1'b1);
      repeat (20) @(negedge clock);

      send(8'h0A, 1'b1);
      send(8'h41, 1'b1);
      send(8'h42, 1'b1);
      repeat (20) @(negedge clock);

      // Short low glitch must be rejected at the start-bit sample.
      ser_rx = 1'b0;
      repeat (4) @(negedge clock);
      ser_rx = 1'b1;
      @(negedge clock);
      chk("glitch_busy_mid", busy, 1);
      repeat (7) @(negedge clock);
      chk("glitch_busy_clear", busy, 0);
      repeat (10) @(negedge clock);

      send(8'hAB, 1'b0);
      repeat (40) @(negedge clock);
      chk("break_busy_held", busy, 1);
      ser_rx = 1'b1;
      repeat (5) @(negedge clock);
      chk("break_busy_clear", busy, 0);
      send(8'h3E, 1'b1);
      repeat (20) @(negedge clock);

      // Abort 0x44 partway through its data bits.
      ser_rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         ser_rx = (i == 2);
         repeat (CPB) @(negedge clock);
      end
      resetb = 1'b0;
      @(negedge clock);
      chk_outputs_zero("mid_reset");
      ser_rx = 1'b1;
      repeat (4) @(negedge clock);
      resetb    = 1'b1;
      last_good = 8'h00;
      repeat (10) @(negedge clock);
      send(8'h50, 1'b1);
      repeat (20) @(negedge clock);

      send_rate(8'h00, 392.0);
      repeat (30) @(negedge clock);
      send_rate(8'hFF, 392.0);
      repeat (30) @(negedge clock);
      send_rate(8'h00, 408.0);
      repeat (30) @(negedge clock);
      send_rate(8'hFF, 408.0);
      repeat (30) @(negedge clock);

      for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clock);
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_pulse: got none expected %s data %h",
                  mon_e.is_err ? "frame_err" : "rx_valid", mon_e.data);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500us;
      $display("FAIL timeout: got no completion expected finish within 500us");
      $fatal(1, "simulation timeout");
   end

endmodule

`default_nettype wire
